load_counter_arb: RTL and testbench
===================================

LOAD_COUNTER_ARB -- requirements
Module: load_counter_arb

Interface
REQ-001 The block SHALL have parameter TERM, default 4'hF, which is the terminal count value that ends an ownership period.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: one request bit per requester (bit i is requester i), level-sensitive.
REQ-005 The block SHALL have port req_data, input, 16 bits: requester i's preset value on req_data[4i+3:4i].
REQ-006 The block SHALL have port q, input, 4 bits: the current value of the attached load counter.
REQ-007 The block SHALL have port load, output, 1 bit: the load strobe to the counter.
REQ-008 The block SHALL have port data, output, 4 bits: the preset value to the counter.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot owner of the counter, or zero when no requester owns it.
REQ-010 The block SHALL have port done, output, 4 bits: a one-hot, one-cycle completion pulse for the owner.
REQ-011 The block SHALL have port busy, output, 1 bit: high while any requester owns the counter.

Function
REQ-012 The block SHALL treat the attached counter as follows: the counter samples load at the clock edge, after which q = data; otherwise it increments by 1 per clock and wraps from 15 to 0.
REQ-013 The block SHALL drive all outputs from registers (Moore style), with no combinational path from any input to any output.
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-015 In IDLE, the FSM SHALL drive grant=0, load=0, done=0 and busy=0. If req!=0, it SHALL select a winner by round-robin and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin SHALL search from pointer+1 upward (mod 4); pointer SHALL take the winner's index on entry to LOAD.
REQ-017 On entry to LOAD, the block SHALL latch req_data for the winner into data; data SHALL then hold until the next grant.
REQ-018 In LOAD, the block SHALL drive load=1, grant=winner (one-hot) and busy=1 for exactly one cycle, then go to RUN.
REQ-019 In RUN, the block SHALL drive load=0 and keep grant and busy held.
REQ-020 In RUN, if q==TERM, the FSM SHALL go to DONE.
REQ-021 In RUN, if the owner's req bit is 0 and q!=TERM, the FSM SHALL go to IDLE (abort) with no done pulse.
REQ-022 In RUN, if q==TERM and the owner's req bit is 0 in the same cycle, completion SHALL win: the FSM goes to DONE.
REQ-023 In DONE, the block SHALL drive done[owner]=1 for one cycle, with grant and busy still asserted, then go to IDLE.
REQ-024 The FSM SHALL always spend at least one cycle in IDLE between owners.
REQ-025 Latency: when req rises in IDLE in cycle N, load and grant SHALL be asserted in cycle N+1.
REQ-026 With preset d, RUN SHALL last ((TERM-d) mod 16)+1 cycles; if d==TERM, RUN SHALL last 1 cycle.
REQ-027 During LOAD, RUN and DONE, changes on req_data and on non-owner req bits SHALL be ignored.
REQ-028 Requests SHALL NOT be queued: a request pending when the FSM returns to IDLE is arbitrated fresh.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set state=IDLE, pointer=3, grant=0, load=0, data=0, done=0 and busy=0.
REQ-030 When rst is asserted in any state, including mid-RUN, all outputs SHALL be 0 from the following cycle, with no done pulse.
REQ-031 rst SHALL take priority over all other inputs.

Verification
REQ-032 Single request: req=0001 with req_data[3:0]=5 -> next cycle grant=0001, load=1, data=5; RUN for 11 cycles while q=5..15; done=0001 in the 12th cycle after the load cycle; then IDLE with busy=0.
REQ-033 Fairness: all req=1111 held from reset, all presets=4'hE -> grants SHALL occur in the order 0001, 0010, 0100, 1000, 0001, with each done preceding the next grant by 2 cycles (DONE then IDLE).
REQ-034 Terminal preset: req=0100 with preset 4'hF -> load in cycle L, RUN in L+1, done=0100 in L+2.
REQ-035 Abort: req=0001 with preset 0; owner req drops while q=3 -> next cycle IDLE, grant=0, no done; pointer=0, so a subsequent req=0011 grants 0010.
REQ-036 Reset mid-RUN: rst pulsed for one cycle while q=7 -> outputs all 0 in the next cycle; then req=1001 -> grant=0001 (pointer=3 after reset).
REQ-037 Ignored input: req_data for the owner changes during RUN -> data and done timing SHALL be unchanged.

Source files
------------

// File: rtl/load_counter_arb.sv
// Round-robin arbiter that lends a single external load counter to four
// requesters. The winner's preset is strobed into the counter, ownership
// lasts until the counter reaches TERM, and the owner then gets a one-cycle
// done pulse. All outputs are registered.
module load_counter_arb #(
    parameter logic [3:0] TERM = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] req_data,
    input  logic [3:0]  q,
    output logic        load,
    output logic [3:0]  data,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy
);
    // state | meaning
    // IDLE  | no owner; arbitrate any pending requests
    // LOAD  | strobe the owner's preset into the counter
    // RUN   | counter advancing toward TERM; owner may abort by dropping req
    // DONE  | one-cycle completion pulse to the owner
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] data_nxt;
    logic [1:0] winner;
    logic       found;
    logic [3:0] owner_oh_nxt;

    // Round-robin search starting one position past the last winner.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
                found  = 1'b1;
            end
        end
    end

    // Next-state, owner, pointer and preset selection.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        data_nxt  = data;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOAD;
                    owner_nxt = winner;
                    ptr_nxt   = winner;
                    data_nxt  = req_data[{winner, 2'b00} +: 4];
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                // completion beats a simultaneous request drop
                if (q == TERM) begin
                    state_nxt = DONE;
                end else if (!req[owner]) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        owner_oh_nxt = 4'b0001 << owner_nxt;
    end

    // State register plus outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd3;
            data  <= 4'd0;
            load  <= 1'b0;
            grant <= 4'd0;
            done  <= 4'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            data  <= data_nxt;
            load  <= (state_nxt == LOAD);
            busy  <= (state_nxt != IDLE);
            grant <= (state_nxt != IDLE) ? owner_oh_nxt : 4'd0;
            done  <= (state_nxt == DONE) ? owner_oh_nxt : 4'd0;
        end
    end
endmodule

// File: tb/tb_load_counter_arb.sv
// Bench for load_counter_arb: models the attached counter, keeps a
// session-level reference model, and runs directed plus random traffic.
module tb_load_counter_arb;
    localparam logic [3:0] TERM = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  q = 4'd0;
    logic        load;
    logic [3:0]  data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    load_counter_arb #(.TERM(TERM)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .q(q),
        .load(load), .data(data), .grant(grant), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // attached counter: load preset or free-run with wrap
    always @(posedge clk) q <= load ? data : q + 4'd1;

    // Reference model: a session is a grant followed by a run of known
    // length. m_t = 0 is the load cycle, 1..m_runlen the run, m_runlen+1 done.
    bit         m_active = 0;
    int         m_owner  = 0;
    int         m_ptr    = 3;
    int         m_t      = 0;
    int         m_runlen = 0;
    logic [3:0] m_data   = 4'd0;

    always @(posedge clk) begin : model
        bit         na;
        int         no, np, nt, nr, w;
        logic [3:0] nd;
        na = m_active; no = m_owner; np = m_ptr; nt = m_t; nr = m_runlen; nd = m_data;
        w  = -1;
        if (rst) begin
            na = 0; np = 3; nd = 4'd0; nt = 0;
        end else if (!m_active) begin
            if (req != 4'd0) begin
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                na = 1; no = w; np = w; nt = 0;
                nd = req_data[4*w +: 4];
                nr = ((int'(TERM) - int'(nd) + 16) % 16) + 1;
            end
        end else if (m_t == 0) begin
            nt = 1;
        end else if (m_t < m_runlen) begin
            if (!req[m_owner]) na = 0;
            else nt = m_t + 1;
        end else if (m_t == m_runlen) begin
            nt = m_t + 1;
        end else begin
            na = 0;
        end
        m_active <= na; m_owner <= no; m_ptr <= np; m_t <= nt; m_runlen <= nr; m_data <= nd;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        logic [3:0] eg, ed;
        logic       el, eb;
        if (chk_en) begin
            eg = m_active ? 4'(1 << m_owner) : 4'd0;
            el = m_active && (m_t == 0);
            ed = (m_active && (m_t == m_runlen + 1)) ? eg : 4'd0;
            eb = m_active;
            vectors++;
            if ({grant, load, done, busy, data} !== {eg, el, ed, eb, m_data}) begin
                miscompares++;
                $display("FAIL model @%0t got grant=%b load=%b done=%b busy=%b data=%h, want grant=%b load=%b done=%b busy=%b data=%h",
                         $time, grant, load, done, busy, data, eg, el, ed, eb, m_data);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Cycles from the current negedge until done is seen (bounded).
    task automatic count_to_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 4'd0 && n < 60);
    endtask

    task automatic wait_q(input logic [3:0] v);
        int n = 0;
        while (q !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_q_bound", int'(n < 40), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int g;
        int gr[5];
        int lc[5];
        int dc[5];
        int d_i;
        int cyc;

        rst = 1'b1; req = 4'd0; req_data = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_load",  load,  0);
        check("rst_done",  done,  0);
        check("rst_busy",  busy,  0);
        check("rst_data",  data,  0);
        chk_en = 1;
        rst = 1'b0;

        // single request, preset 5
        req = 4'b0001; req_data = 16'h0005;
        @(negedge clk);
        check("single_grant", grant, 1);
        check("single_load",  load,  1);
        check("single_data",  data,  5);
        check("model_runlen", m_runlen, 11);
        count_to_done(n);
        check("single_done_cycle", n, 12);
        check("single_done", done, 1);
        req = 4'd0;
        @(negedge clk);
        check("single_idle_busy",  busy,  0);
        check("single_idle_grant", grant, 0);

        // terminal preset on requester 2
        req = 4'b0100; req_data = 16'h0F00;
        @(negedge clk);
        check("term_grant", grant, 4);
        check("term_load",  load,  1);
        count_to_done(n);
        check("term_done_cycle", n, 2);
        check("term_done", done, 4);
        req = 4'd0;
        @(negedge clk);

        // abort while q == 3, then pointer at 0 makes 0011 grant requester 1
        req = 4'b0001; req_data = 16'h0000;
        @(negedge clk);
        check("abort_grant", grant, 1);
        @(negedge clk);
        wait_q(4'd3);
        req = 4'd0;
        @(negedge clk);
        check("abort_grant_off", grant, 0);
        check("abort_busy",      busy,  0);
        check("abort_no_done",   done,  0);
        req = 4'b0011;
        @(negedge clk);
        check("abort_next_grant", grant, 2);
        req = 4'd0;
        repeat (2) @(negedge clk);
        check("abort2_busy", busy, 0);

        // reset mid-run at q == 7
        req = 4'b0001; req_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        wait_q(4'd7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", grant, 0);
        check("midrst_load",  load,  0);
        check("midrst_done",  done,  0);
        check("midrst_busy",  busy,  0);
        check("midrst_data",  data,  0);
        rst = 1'b0; req = 4'b1001;
        @(negedge clk);
        check("midrst_ptr_grant", grant, 1);
        req = 4'd0;
        repeat (2) @(negedge clk);
        check("midrst_after_busy", busy, 0);

        // owner preset changes during run are ignored
        req = 4'b0001; req_data = 16'h0005;
        @(negedge clk);
        check("ign_data0", data, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            req_data = 16'($urandom);
        end while (done == 4'd0 && n < 60);
        check("ign_done_cycle", n, 12);
        check("ign_data", data, 5);
        req = 4'd0;
        @(negedge clk);

        // fairness: all requesters, presets E, from reset
        rst = 1'b1; req = 4'hF; req_data = 16'hEEEE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        g = 0; d_i = 0; cyc = 0;
        while (g < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (load) begin gr[g] = grant; lc[g] = cyc; g++; end
            if (done != 4'd0 && d_i < 5) begin dc[d_i] = cyc; d_i++; end
        end
        check("fair_count", g, 5);
        if (g == 5) begin
            check("fair_g0", gr[0], 1);
            check("fair_g1", gr[1], 2);
            check("fair_g2", gr[2], 4);
            check("fair_g3", gr[3], 8);
            check("fair_g4", gr[4], 1);
            for (int i = 0; i < 4; i++) begin
                check("fair_run_len", dc[i] - lc[i], 3);
                check("fair_gap", lc[i+1] - dc[i], 2);
            end
        end
        req = 4'd0;
        repeat (20) @(negedge clk);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 2) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) req_data = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; req = 4'd0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
